// File: rtl/display_regs_pkg.sv
// Shared definitions for the display register path: register numbers, legal
// value limits, screen codes and the commit FSM encoding.
package display_regs_pkg;

    localparam int unsigned MIF_REG      = 30;
    localparam int unsigned DIE_BASE_REG = 25;
    localparam int unsigned NUM_DICE     = 5;
    localparam int unsigned MAX_SCREEN   = 3;
    localparam int unsigned MAX_FACE     = 6;

    localparam logic [31:0] SCR_START  = 32'd0;
    localparam logic [31:0] SCR_PLAYER = 32'd1;
    localparam logic [31:0] SCR_LEADER = 32'd2;
    localparam logic [31:0] SCR_BOARD  = 32'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } bridge_state_e;

    function automatic logic is_die_addr(input logic [4:0] addr);
        return (addr >= 5'(DIE_BASE_REG)) && (addr < 5'(DIE_BASE_REG + NUM_DICE));
    endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Detects the falling edge of an active-low vertical sync; the pulse is one clock wide.
// A fall is only reported once vs_n has been seen high since reset.
module vsync_edge_det (
    input  logic vga_clk,
    input  logic reset,
    input  logic vs_n,
    output logic vs_fall
);

    logic vs_d_q;
    logic seen_high_q;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            vs_d_q      <= 1'b1;
            seen_high_q <= 1'b0;
        end else begin
            vs_d_q      <= vs_n;
            seen_high_q <= seen_high_q | vs_n;
        end
    end

    // Gating with seen_high_q keeps a sync held low across reset from looking like a new frame.
    assign vs_fall = vs_d_q & ~vs_n & seen_high_q;

endmodule

// File: rtl/display_reg_bridge.sv
// Shadows processor writes to the display registers and commits them as one set
// at the start of vertical sync; also counts frames.
module display_reg_bridge
    import display_regs_pkg::*;
(
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        reg_we,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        vs_n,
    output logic [31:0] mif_toggle,
    output logic [31:0] die1,
    output logic [31:0] die2,
    output logic [31:0] die3,
    output logic [31:0] die4,
    output logic [31:0] die5,
    output logic [31:0] ctr,
    output logic        pending,
    output logic        bad_write
);

    logic vs_fall;

    vsync_edge_det u_vsync_edge_det (
        .vga_clk (vga_clk),
        .reset   (reset),
        .vs_n    (vs_n),
        .vs_fall (vs_fall)
    );

    bridge_state_e state_q;
    logic [31:0]   shadow_mif_q;
    logic [31:0]   shadow_die_q [NUM_DICE];
    logic [31:0]   mif_q;
    logic [31:0]   die_q [NUM_DICE];
    logic [31:0]   ctr_q;
    logic          pending_q;
    logic          bad_write_q;

    logic          mif_hit;
    logic          mif_legal;
    logic          die_hit;
    logic [2:0]    die_idx;
    logic [31:0]   die_val;

    always_comb begin
        mif_hit   = reg_we && (reg_addr == 5'(MIF_REG));
        mif_legal = (reg_wdata <= 32'(MAX_SCREEN));
        die_hit   = reg_we && is_die_addr(reg_addr);
        die_idx   = 3'(reg_addr - 5'(DIE_BASE_REG));
        die_val   = (reg_wdata <= 32'(MAX_FACE)) ? reg_wdata : 32'd0;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shadow_mif_q <= SCR_START;
            mif_q        <= SCR_START;
            ctr_q        <= 32'd0;
            pending_q    <= 1'b0;
            bad_write_q  <= 1'b0;
            // NOTE: the shadow and output dice are reset too; a reset must drop any uncommitted faces.
            for (int k = 0; k < NUM_DICE; k++) begin
                shadow_die_q[k] <= 32'd0;
                die_q[k]        <= 32'd0;
            end
        end else begin
            if (vs_fall) begin
                ctr_q <= ctr_q + 32'd1;
                if (state_q == ST_ARMED) begin
                    mif_q     <= shadow_mif_q;
                    die_q     <= shadow_die_q;
                    state_q   <= ST_IDLE;
                    pending_q <= 1'b0;
                end
            end
            // NOTE: non-blocking reads above see the pre-write shadow, and these later
            // assignments win, so a write on the commit cycle stays armed for the next frame.
            if (mif_hit) begin
                if (mif_legal) begin
                    shadow_mif_q <= reg_wdata;
                    state_q      <= ST_ARMED;
                    pending_q    <= 1'b1;
                end else begin
                    bad_write_q  <= 1'b1;
                end
            end
            if (die_hit) begin
                shadow_die_q[die_idx] <= die_val;
                state_q               <= ST_ARMED;
                pending_q             <= 1'b1;
            end
        end
    end

    assign mif_toggle = mif_q;
    assign die1       = die_q[0];
    assign die2       = die_q[1];
    assign die3       = die_q[2];
    assign die4       = die_q[3];
    assign die5       = die_q[4];
    assign ctr        = ctr_q;
    assign pending    = pending_q;
    assign bad_write  = bad_write_q;

endmodule
